// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word RAM access with wait states and a stall
// handshake, misalignment errors, and a 16-byte MMIO window (LEDs, switches, cycle counter).
module dmem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall,
    input  logic [31:0] mmio_in,
    output logic [31:0] mmio_out
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t                state, state_nxt;
    logic                  accept, perform;
    logic [3:0]            cnt;
    logic                  we_q, sext_q;
    logic [1:0]            size_q;
    logic [31:0]           addr_q, wdata_q;
    logic [31:0]           cyc_cnt;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_mmio, acc_err;
    logic [31:0]           rd_word, load_val, mmio_rd, wd_lane;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [3:0]            be;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves an output unassigned (no latch).
        state_nxt = state;
        accept    = 1'b0;
        perform   = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (cnt == 4'd0) begin
                perform   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                accept    = req;
                state_nxt = req ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready   = (state == RESP);
    assign stall   = req & ~ready;
    assign idx     = addr_q[ADDR_WIDTH+1:2];
    assign is_mmio = (addr_q[31:4] == MMIO_BASE[31:4]);

    // The MMIO window only supports word accesses.
    always_comb begin
        case (size_q)
            SZ_BYTE: acc_err = 1'b0;
            SZ_HALF: acc_err = addr_q[0];
            SZ_WORD: acc_err = (addr_q[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (is_mmio && size_q != SZ_WORD) acc_err = 1'b1;
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (addr_q[3:2])
            2'b00:   mmio_rd = mmio_out;
            2'b01:   mmio_rd = mmio_in;
            2'b10:   mmio_rd = cyc_cnt;
            default: mmio_rd = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the addressed ones.
    always_comb begin
        be      = 4'b1111;
        wd_lane = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_q[1:0];
                wd_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_lane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            mmio_out <= 32'd0;
            cyc_cnt  <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (accept) begin
                we_q    <= we;
                sext_q  <= sign_ext;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CNT_LOAD;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (perform) begin
                err <= acc_err;
                if (acc_err)      rdata <= 32'd0;
                else if (is_mmio) rdata <= mmio_rd;
                else              rdata <= load_val;
                if (!acc_err && is_mmio && we_q && addr_q[3:2] == 2'b00)
                    mmio_out <= wdata_q;
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (perform && we_q && !acc_err && !is_mmio) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances with WAIT_CYCLES = 1, 0 and 3
// covering lanes, misalignment, MMIO, back-to-back timing and reset during BUSY.
module tb_dmem_ctrl;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic        req      [3];
    logic        we       [3];
    logic [31:0] addr     [3];
    logic [1:0]  size     [3];
    logic        sign_ext [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];
    logic        ready    [3];
    logic        err      [3];
    logic        stall    [3];
    logic [31:0] mmio_out [3];
    logic [31:0] mmio_in;

    int n_checks = 0;
    int n_errors = 0;
    int exp_lat [3] = '{3, 2, 5};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        dmem_ctrl #(
            .ADDR_WIDTH (7),
            .WAIT_CYCLES(W),
            .MMIO_BASE  (32'hFFFF_0000)
        ) u_dut (
            .clk     (clk),
            .reset   (rst[g]),
            .req     (req[g]),
            .we      (we[g]),
            .addr    (addr[g]),
            .size    (size[g]),
            .sign_ext(sign_ext[g]),
            .wdata   (wdata[g]),
            .rdata   (rdata[g]),
            .ready   (ready[g]),
            .err     (err[g]),
            .stall   (stall[g]),
            .mmio_in (mmio_in),
            .mmio_out(mmio_out[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request (mid-cycle A), waits for ready with a bounded budget.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output int lat,
                          output logic st_busy, output logic st_resp);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; size[d] = sz; sign_ext[d] = sx; wdata[d] = wd;
        lat = 0;
        st_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) st_busy = stall[d];
        end while (!ready[d] && lat < 40);
        rd = rdata[d];
        e = err[d];
        st_resp = stall[d];
        req[d] = 1'b0;
        we[d] = 1'b0;
    endtask

    task automatic ld(input string tag, input int d, input logic [31:0] a, input logic [1:0] sz,
                      input logic sx, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic e, sb, sr;
        int lat;
        access(d, 1'b0, a, sz, sx, 32'd0, rd, e, lat, sb, sr);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_lat"}, lat, exp_lat[d]);
        check({tag, "_stall_busy"}, sb, 1'b1);
        check({tag, "_stall_resp"}, sr, 1'b0);
    endtask

    task automatic st(input string tag, input int d, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input logic exp_err);
        logic [31:0] rd;
        logic e, sb, sr;
        int lat;
        access(d, 1'b1, a, sz, 1'b0, wd, rd, e, lat, sb, sr);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_lat"}, lat, exp_lat[d]);
        check({tag, "_stall_busy"}, sb, 1'b1);
    endtask

    initial begin
        logic [31:0] c1, c2, rd;
        logic        e, sb, sr;
        int          lat, pulses;
        logic [8:0]  pattern;
        logic [31:0] b2b_exp [3];

        mmio_in = 32'd0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0;
            size[i] = SZ_W; sign_ext[i] = 1'b0; wdata[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", ready[i], 1'b0);
            check("rst_err", err[i], 1'b0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_mmio_out", mmio_out[i], 32'd0);
            check("rst_stall", stall[i], 1'b0);
            rst[i] = 1'b0;
        end

        // Word store/load, aliasing of upper address bits.
        st("sw_10", 0, 32'h0000_0010, SZ_W, 32'hDEAD_BEEF, 1'b0);
        ld("lw_10", 0, 32'h0000_0010, SZ_W, 1'b0, 32'hDEAD_BEEF, 1'b0);
        ld("lw_alias", 0, 32'h1000_0010, SZ_W, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Byte and halfword lanes.
        st("sw_20", 0, 32'h20, SZ_W, 32'h1122_3344, 1'b0);
        ld("lb_23s", 0, 32'h23, SZ_B, 1'b1, 32'h0000_0011, 1'b0);
        st("sb_21", 0, 32'h21, SZ_B, 32'h1234_5680, 1'b0);
        ld("lb_21s", 0, 32'h21, SZ_B, 1'b1, 32'hFFFF_FF80, 1'b0);
        ld("lb_21u", 0, 32'h21, SZ_B, 1'b0, 32'h0000_0080, 1'b0);
        ld("lh_22", 0, 32'h22, SZ_H, 1'b1, 32'h0000_1122, 1'b0);
        st("sh_22", 0, 32'h22, SZ_H, 32'h0000_A5B6, 1'b0);
        ld("lh_22s", 0, 32'h22, SZ_H, 1'b1, 32'hFFFF_A5B6, 1'b0);
        ld("lw_20a", 0, 32'h20, SZ_W, 1'b0, 32'hA5B6_8044, 1'b0);

        // Misalignment and illegal size leave RAM untouched.
        ld("lw_22_mis", 0, 32'h22, SZ_W, 1'b0, 32'd0, 1'b1);
        st("sh_21_mis", 0, 32'h21, SZ_H, 32'h0000_FFFF, 1'b1);
        st("sw_x_ill", 0, 32'h20, SZ_X, 32'h0, 1'b1);
        ld("lw_20b", 0, 32'h20, SZ_W, 1'b0, 32'hA5B6_8044, 1'b0);

        // MMIO window.
        st("mmio_led", 0, 32'hFFFF_0000, SZ_W, 32'h0000_005A, 1'b0);
        check("mmio_out_5a", mmio_out[0], 32'h0000_005A);
        mmio_in = 32'h0000_1234;
        ld("mmio_sw", 0, 32'hFFFF_0004, SZ_W, 1'b0, 32'h0000_1234, 1'b0);
        st("mmio_sw_wr", 0, 32'hFFFF_0004, SZ_W, 32'hFFFF_FFFF, 1'b0);
        check("mmio_out_keep", mmio_out[0], 32'h0000_005A);
        access(0, 1'b0, 32'hFFFF_0008, SZ_W, 1'b0, 32'd0, c1, e, lat, sb, sr);
        check("cyc1_err", e, 1'b0);
        access(0, 1'b0, 32'hFFFF_0008, SZ_W, 1'b0, 32'd0, c2, e, lat, sb, sr);
        check("cyc_delta", c2 - c1, 32'd4);
        ld("mmio_c", 0, 32'hFFFF_000C, SZ_W, 1'b0, 32'd0, 1'b0);
        ld("mmio_lb_err", 0, 32'hFFFF_0000, SZ_B, 1'b0, 32'd0, 1'b1);
        ld("mmio_led_rd", 0, 32'hFFFF_0000, SZ_W, 1'b0, 32'h0000_005A, 1'b0);

        // Back-to-back loads with req held, WAIT_CYCLES = 0.
        st("b2b_sw0", 1, 32'h40, SZ_W, 32'h0000_00A1, 1'b0);
        st("b2b_sw1", 1, 32'h44, SZ_W, 32'h0000_00B2, 1'b0);
        st("b2b_sw2", 1, 32'h48, SZ_W, 32'h0000_00C3, 1'b0);
        b2b_exp = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3};
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_W; addr[1] = 32'h40;
        pulses = 0;
        pattern = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            pattern[c] = ready[1];
            if (ready[1]) begin
                if (pulses < 3) check("b2b_rdata", rdata[1], b2b_exp[pulses]);
                pulses++;
                if (pulses >= 3) req[1] = 1'b0;
                else addr[1] = 32'h40 + 32'(4 * pulses);
            end
        end
        check("b2b_pattern", 32'(pattern), 32'h0000_0054);
        check("b2b_pulses", pulses, 32'd3);

        // Reset during BUSY of a store, WAIT_CYCLES = 3.
        st("rst_sw_30", 2, 32'h30, SZ_W, 32'hCAFE_F00D, 1'b0);
        ld("rst_mis", 2, 32'h31, SZ_W, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = SZ_W; addr[2] = 32'h30; wdata[2] = 32'h0BAD_BEEF;
        @(negedge clk);
        check("rst_busy1_stall", stall[2], 1'b1);
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        check("rst_async_ready", ready[2], 1'b0);
        check("rst_async_err", err[2], 1'b0);
        check("rst_async_rdata", rdata[2], 32'd0);
        req[2] = 1'b0;
        we[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        ld("rst_lw_30", 2, 32'h30, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b0);
        st("rst_sw_34", 2, 32'h34, SZ_W, 32'h1234_5678, 1'b0);
        ld("rst_lw_34", 2, 32'h34, SZ_W, 1'b0, 32'h1234_5678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller that replaces the fixed single-cycle word RAM behind the pipeline CPU's data port. It adds byte/halfword access with sign or zero extension, a configurable number of wait states with a stall handshake to the pipeline, misalignment detection, and a small memory-mapped I/O window (LED register, switch input, cycle counter). It sits between the CPU's memory stage and the board I/O inside the top-level SoC wrapper.

## Interface

- `ADDR_WIDTH`, 7: word-address bits; RAM depth is 2^ADDR_WIDTH words of 32 bits.
- `WAIT_CYCLES`, 1: extra cycles per access, legal range 0..15.
- `MMIO_BASE`, 32'hFFFF_0000: base of the 16-byte MMIO window; only bits [31:4] are compared.

- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: access request, held by the CPU until `ready`.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata` out 32: load result, valid only while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `ready`; access was rejected.
- `stall` out 1: combinational `req & ~ready`; freezes the pipeline.
- `mmio_in` in 32: switch inputs.
- `mmio_out` out 32: LED register.

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: if `req`=1 at the edge, latch `we`/`addr`/`size`/`sign_ext`/`wdata`, load `cnt`<=WAIT_CYCLES, go BUSY.
- BUSY: if `cnt`!=0, decrement. If `cnt`==0, perform the access at this edge, register `rdata`/`err`, go RESP.
- RESP: `ready`=1 for exactly one cycle. If `req`=1 at this edge, accept a new request (go BUSY, as from IDLE); else go IDLE. The CPU must present the next request or drop `req` in RESP.
- Error cases:
  - Halfword access with `addr[0]`=1, word access with `addr[1:0]`!=0, `size`=11, or any non-word MMIO access.
  - Result: no write, `rdata`=0, `err`=1 with `ready`.
- RAM:
  - Index is `addr[ADDR_WIDTH+1:2]`; upper address bits are ignored outside the MMIO window.
  - Little-endian lanes: byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - Stores update only the addressed lanes.
  - Loads extract the addressed lane(s), then sign- or zero-extend to 32 bits. Word loads ignore `sign_ext`.
- MMIO (when `addr[31:4]`==`MMIO_BASE[31:4]`), by offset:
  - 0x0: LED register, read/write.
  - 0x4: `mmio_in`, read-only; writes ignored, no `err`.
  - 0x8: free-running 32-bit cycle counter, read-only; wraps 0xFFFF_FFFF->0.
  - 0xC: reads 0, writes ignored.
  - MMIO reads sample at the BUSY edge that performs the access.

## Timing

- Request accepted at the edge ending cycle A. `ready` is high in cycle A+2+WAIT_CYCLES. With WAIT_CYCLES=0, `ready` is high in A+2.
- A store's RAM/LED update occurs at the edge ending cycle A+1+WAIT_CYCLES. A load of the same address accepted in RESP sees the new value.
- Back-to-back throughput: one access per 2+WAIT_CYCLES cycles.
- Inputs are sampled only at accept. Changes to `addr`/`wdata` while in BUSY have no effect.
- Reset values: state IDLE, `cnt`=0, `ready`=0, `err`=0, `rdata`=0, `mmio_out`=0, cycle counter=0. RAM contents are not reset.
- Reset asserted during BUSY: the access is abandoned, and no write occurs if the performing edge has not yet passed. Outputs go to reset values immediately (asynchronously).
- `stall` depends combinationally on `req`. It is 0 whenever `req`=0, and 0 in RESP.

## Test plan

- Word store then load, WAIT_CYCLES=1: store 0xDEADBEEF to addr 0x10, then load it -> `rdata`=0xDEADBEEF, `ready` 3 cycles after each accept, `stall`=1 during BUSY.
- Byte/half lanes: word 0x11223344 at 0x20; `lb` 0x23 signed -> 0x00000011; store byte 0x80 to 0x21, `lb` 0x21 signed -> 0xFFFFFF80, unsigned -> 0x00000080; `lh` 0x22 -> 0x00001122.
- Misalignment: word load at 0x22 and halfword store at 0x21 -> `err`=1, `rdata`=0, RAM unchanged (verify by word reads).
- MMIO: word store 0x5A to 0xFFFF0000 -> `mmio_out`=0x5A; `mmio_in`=0x1234 -> load 0xFFFF0004 returns 0x1234; two loads of 0xFFFF0008 differ by the cycle spacing; byte load at 0xFFFF0000 -> `err`=1.
- Back-to-back: `req` held high across 3 loads with WAIT_CYCLES=0 -> `ready` pulses every 2 cycles, never 2 consecutive cycles.
- Reset during BUSY of a store to 0x30 (WAIT_CYCLES=3, reset in second BUSY cycle) -> `ready`/`err` drop immediately, word at 0x30 unchanged, next request completes normally.
